// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control sequencer for the MIPS datapath. The instruction latched
// in the IR is decoded and stepped through FETCH/DECODE/EXE/MEM/WB/BR/JMP.
// Every datapath strobe and path select is combinational from the current
// state and instr. Only the state register and the retired counter hold state.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous reset, active low
//   instr      : IR contents from the datapath (valid from DECODE onward)
//   zero       : ALU result == 0 (beq compare)
//   gtz        : GPR[rs] signed > 0 (bgtz)
//   dm_ready   : data memory access completes this cycle (MEM only)
//   pc_write   : PC load strobe
//   ir_write   : IR load strobe
//   npc_sel    : 0 PC+4, 1 branch target, 2 jump target, 3 GPR[rs]
//   reg_dst    : 0 rt, 1 rd, 2 RA_IDX
//   alu_src    : 0 GPR[rt], 1 extended imm16
//   mem_to_reg : 0 ALU, 1 DM, 2 PC+4
//   gpr_write  : register file write strobe
//   dm_write   : data memory write strobe
//   dm_req     : data memory access request
//   sign_ext   : 1 sign-extend imm16, 0 zero-extend
//   lui_ext    : imm16 << 16
//   alu_op     : 000 addu, 001 subu, 010 or, 011 sll
//   illegal    : one-cycle pulse in DECODE on an unsupported encoding
//   state      : current state (debug)
//   retired    : count of completed instructions, wraps modulo 2^CNT_W
module mc_controller #(
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             gtz,
  input  logic             dm_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       npc_sel,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [1:0]       mem_to_reg,
  output logic             gpr_write,
  output logic             dm_write,
  output logic             dm_req,
  output logic             sign_ext,
  output logic             lui_ext,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BR     = 3'd5,
    S_JMP    = 3'd6
  } state_t;

  // The write-address mux in the datapath owns the RA_IDX constant.
  // The controller only selects it via reg_dst=2.
  localparam logic [4:0] RA_IDX_L = 5'(RA_IDX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic [5:0] opcode, funct;
  logic is_r, is_addu, is_subu, is_sll, is_jr;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_bgtz, is_jal;
  logic to_exe, to_br, to_jmp;

  // Raw (reset-unmasked) strobes
  logic pc_write_c, ir_write_c, gpr_write_c, dm_write_c, dm_req_c, illegal_c;

  // shamt, rs/rt/rd and imm fields are consumed by the datapath directly.
  logic unused_ok;
  assign unused_ok = ^{instr[25:6], RA_IDX_L};

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  assign is_r    = (opcode == 6'b000000);
  assign is_addu = is_r && (funct == 6'b100001);
  assign is_subu = is_r && (funct == 6'b100011);
  assign is_sll  = is_r && (funct == 6'b000000);
  assign is_jr   = is_r && (funct == 6'b001000);
  assign is_ori  = (opcode == 6'b001101);
  assign is_lui  = (opcode == 6'b001111);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_bgtz = (opcode == 6'b000111);
  assign is_jal  = (opcode == 6'b000011);

  assign to_exe = is_addu | is_subu | is_sll | is_ori | is_lui | is_lw | is_sw;
  assign to_br  = is_beq | is_bgtz;
  assign to_jmp = is_jal | is_jr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    gpr_write_c = 1'b0;
    dm_write_c  = 1'b0;
    dm_req_c    = 1'b0;
    illegal_c   = 1'b0;
    npc_sel     = 2'd0;
    reg_dst     = 2'd0;
    alu_src     = 1'b0;
    mem_to_reg  = 2'd0;
    sign_ext    = 1'b0;
    lui_ext     = 1'b0;
    alu_op      = 3'b000;

    // ALU controls stay steady from EXE through WB so the datapath sees a
    // stable operation while the address or result is consumed.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      if (is_lw || is_sw) begin
        alu_op   = 3'b000;
        alu_src  = 1'b1;
        sign_ext = 1'b1;
      end else if (is_ori) begin
        alu_op  = 3'b010;
        alu_src = 1'b1;
      end else if (is_lui) begin
        alu_op  = 3'b010;
        alu_src = 1'b1;
        lui_ext = 1'b1;
      end else if (is_subu) begin
        alu_op = 3'b001;
      end else if (is_sll) begin
        alu_op = 3'b011;
      end
    end

    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        npc_sel    = 2'd0;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        if (to_exe) begin
          state_d = S_EXE;
        end else if (to_br) begin
          state_d = S_BR;
        end else if (to_jmp) begin
          state_d = S_JMP;
        end else begin
          // Unsupported encoding: behaves as a nop that is not counted.
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXE: begin
        state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_req_c   = 1'b1;
        dm_write_c = is_sw;
        if (dm_ready) begin
          if (is_sw) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        gpr_write_c = 1'b1;
        reg_dst     = is_r ? 2'd1 : 2'd0;
        mem_to_reg  = is_lw ? 2'd1 : 2'd0;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_BR: begin
        alu_op     = 3'b001;
        alu_src    = 1'b0;
        npc_sel    = 2'd1;
        // Untaken: PC already holds PC+4 from FETCH.
        pc_write_c = (is_beq & zero) | (is_bgtz & gtz);
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_JMP: begin
        pc_write_c = 1'b1;
        if (is_jal) begin
          npc_sel     = 2'd2;
          gpr_write_c = 1'b1;
          reg_dst     = 2'd2;
          mem_to_reg  = 2'd2;
        end else begin
          npc_sel = 2'd3;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held so nothing is written
  // during reset, even though the state register already sits in FETCH.
  assign pc_write  = pc_write_c  & reset;
  assign ir_write  = ir_write_c  & reset;
  assign gpr_write = gpr_write_c & reset;
  assign dm_write  = dm_write_c  & reset;
  assign dm_req    = dm_req_c    & reset;
  assign illegal   = illegal_c   & reset;
  assign state     = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, gtz, dm_ready;
  logic        pc_write, ir_write, alu_src, gpr_write, dm_write, dm_req;
  logic        sign_ext, lui_ext, illegal;
  logic [1:0]  npc_sel, reg_dst, mem_to_reg;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  int vectors = 0;
  int errors  = 0;

  mc_controller #(.RA_IDX(31), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .gtz(gtz),
    .dm_ready(dm_ready), .pc_write(pc_write), .ir_write(ir_write),
    .npc_sel(npc_sel), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .gpr_write(gpr_write), .dm_write(dm_write),
    .dm_req(dm_req), .sign_ext(sign_ext), .lui_ext(lui_ext),
    .alu_op(alu_op), .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 time units
  // after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; instr = 32'h0; zero = 1'b0; gtz = 1'b0; dm_ready = 1'b0;
    cyc(); cyc();
    chk("rst_state",   32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_irw",     32'(ir_write), 32'd0);
    chk("rst_pcw",     32'(pc_write), 32'd0);
    chk("rst_gprw",    32'(gpr_write), 32'd0);
    chk("rst_dmw",     32'(dm_write), 32'd0);
    chk("rst_dmreq",   32'(dm_req), 32'd0);

    reset = 1'b1; #1;
    chk("fetch_irw", 32'(ir_write), 32'd1);
    chk("fetch_pcw", 32'(pc_write), 32'd1);
    chk("fetch_npc", 32'(npc_sel), 32'd0);

    // addu interrupted by reset in EXE
    instr = 32'h00221821;
    cyc(); chk("ab_dec", 32'(state), 32'd1);
    cyc(); chk("ab_exe", 32'(state), 32'd2);
    reset = 1'b0; #1;
    chk("ab_async_state", 32'(state), 32'd0);
    chk("ab_gprw", 32'(gpr_write), 32'd0);
    cyc(); cyc(); cyc();
    chk("ab_hold_state", 32'(state), 32'd0);
    chk("ab_retired", retired, 32'd0);
    reset = 1'b1; #1;
    chk("ab_rel_irw", 32'(ir_write), 32'd1);
    chk("ab_rel_pcw", 32'(pc_write), 32'd1);

    // addu $3,$1,$2: 0,1,2,4,0
    cyc(); chk("addu_dec", 32'(state), 32'd1);
    cyc(); chk("addu_exe", 32'(state), 32'd2);
    chk("addu_exe_op", 32'(alu_op), 32'd0);
    chk("addu_exe_src", 32'(alu_src), 32'd0);
    cyc(); chk("addu_wb", 32'(state), 32'd4);
    chk("addu_gprw", 32'(gpr_write), 32'd1);
    chk("addu_regdst", 32'(reg_dst), 32'd1);
    chk("addu_m2r", 32'(mem_to_reg), 32'd0);
    chk("addu_op", 32'(alu_op), 32'd0);
    chk("addu_pcw", 32'(pc_write), 32'd0);
    chk("addu_ret_pre", retired, 32'd0);
    cyc(); chk("addu_fetch", 32'(state), 32'd0);
    chk("addu_ret", retired, 32'd1);

    // lw with 3 wait cycles
    instr = 32'h8C220004;
    cyc(); chk("lw_dec", 32'(state), 32'd1);
    cyc(); chk("lw_exe", 32'(state), 32'd2);
    chk("lw_src", 32'(alu_src), 32'd1);
    chk("lw_sext", 32'(sign_ext), 32'd1);
    chk("lw_op", 32'(alu_op), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      dm_ready = (i == 3); #1;
      chk($sformatf("lw_mem%0d", i), 32'(state), 32'd3);
      chk($sformatf("lw_req%0d", i), 32'(dm_req), 32'd1);
      chk($sformatf("lw_dmw%0d", i), 32'(dm_write), 32'd0);
    end
    cyc(); dm_ready = 1'b0; #1;
    chk("lw_wb", 32'(state), 32'd4);
    chk("lw_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_regdst", 32'(reg_dst), 32'd0);
    chk("lw_gprw", 32'(gpr_write), 32'd1);
    chk("lw_dmreq_wb", 32'(dm_req), 32'd0);
    cyc(); chk("lw_fetch", 32'(state), 32'd0);
    chk("lw_ret", retired, 32'd2);

    // sw with zero wait
    instr = 32'hAC220004;
    cyc(); cyc(); chk("sw_exe", 32'(state), 32'd2);
    cyc(); dm_ready = 1'b1; #1;
    chk("sw_mem", 32'(state), 32'd3);
    chk("sw_dmw", 32'(dm_write), 32'd1);
    chk("sw_req", 32'(dm_req), 32'd1);
    chk("sw_gprw", 32'(gpr_write), 32'd0);
    cyc(); dm_ready = 1'b0; #1;
    chk("sw_fetch", 32'(state), 32'd0);
    chk("sw_ret", retired, 32'd3);

    // beq taken
    instr = 32'h10220003;
    cyc(); chk("beqt_dec", 32'(state), 32'd1);
    cyc(); zero = 1'b1; #1;
    chk("beqt_br", 32'(state), 32'd5);
    chk("beqt_pcw", 32'(pc_write), 32'd1);
    chk("beqt_npc", 32'(npc_sel), 32'd1);
    chk("beqt_op", 32'(alu_op), 32'd1);
    chk("beqt_src", 32'(alu_src), 32'd0);
    cyc(); zero = 1'b0; #1;
    chk("beqt_fetch", 32'(state), 32'd0);
    chk("beqt_ret", retired, 32'd4);

    // beq untaken, dm_ready high must be ignored
    dm_ready = 1'b1;
    cyc(); cyc(); #1;
    chk("beqn_br", 32'(state), 32'd5);
    chk("beqn_pcw", 32'(pc_write), 32'd0);
    chk("beqn_dmreq", 32'(dm_req), 32'd0);
    cyc(); dm_ready = 1'b0; #1;
    chk("beqn_fetch", 32'(state), 32'd0);
    chk("beqn_ret", retired, 32'd5);

    // bgtz taken, zero=1 must not matter
    instr = 32'h1C200002;
    cyc(); cyc(); gtz = 1'b1; #1;
    chk("bgtz_br", 32'(state), 32'd5);
    chk("bgtz_pcw", 32'(pc_write), 32'd1);
    gtz = 1'b0; zero = 1'b1; #1;
    chk("bgtz_zero_pcw", 32'(pc_write), 32'd0);
    zero = 1'b0;
    cyc(); chk("bgtz_ret", retired, 32'd6);

    // jal
    instr = 32'h0C000100;
    cyc(); cyc();
    chk("jal_jmp", 32'(state), 32'd6);
    chk("jal_pcw", 32'(pc_write), 32'd1);
    chk("jal_npc", 32'(npc_sel), 32'd2);
    chk("jal_gprw", 32'(gpr_write), 32'd1);
    chk("jal_regdst", 32'(reg_dst), 32'd2);
    chk("jal_m2r", 32'(mem_to_reg), 32'd2);
    chk("jal_dmw", 32'(dm_write), 32'd0);
    cyc(); chk("jal_fetch", 32'(state), 32'd0);
    chk("jal_ret", retired, 32'd7);

    // jr $31
    instr = 32'h03E00008;
    cyc(); cyc();
    chk("jr_jmp", 32'(state), 32'd6);
    chk("jr_pcw", 32'(pc_write), 32'd1);
    chk("jr_npc", 32'(npc_sel), 32'd3);
    chk("jr_gprw", 32'(gpr_write), 32'd0);
    cyc(); chk("jr_ret", retired, 32'd8);

    // ori
    instr = 32'h34220005;
    cyc(); cyc();
    chk("ori_op", 32'(alu_op), 32'd2);
    chk("ori_src", 32'(alu_src), 32'd1);
    chk("ori_sext", 32'(sign_ext), 32'd0);
    chk("ori_lui", 32'(lui_ext), 32'd0);
    cyc(); chk("ori_wb", 32'(state), 32'd4);
    chk("ori_regdst", 32'(reg_dst), 32'd0);
    chk("ori_m2r", 32'(mem_to_reg), 32'd0);
    cyc(); chk("ori_ret", retired, 32'd9);

    // lui
    instr = 32'h3C011234;
    cyc(); cyc();
    chk("lui_ext", 32'(lui_ext), 32'd1);
    chk("lui_op", 32'(alu_op), 32'd2);
    chk("lui_src", 32'(alu_src), 32'd1);
    cyc(); cyc(); chk("lui_ret", retired, 32'd10);

    // subu and sll ALU ops
    instr = 32'h00221823;
    cyc(); cyc(); chk("subu_op", 32'(alu_op), 32'd1);
    cyc(); chk("subu_regdst", 32'(reg_dst), 32'd1);
    cyc();
    instr = 32'h00021080;
    cyc(); cyc(); chk("sll_op", 32'(alu_op), 32'd3);
    cyc(); cyc(); chk("sll_ret", retired, 32'd12);

    // illegal opcode
    instr = 32'hFC000000;
    cyc();
    chk("ill_dec", 32'(state), 32'd1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_gprw", 32'(gpr_write), 32'd0);
    cyc();
    chk("ill_fetch", 32'(state), 32'd0);
    chk("ill_clear", 32'(illegal), 32'd0);
    chk("ill_ret", retired, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational controller.
- Decodes the latched instruction and steps a FETCH/DECODE/EXE/MEM/WB/BR/JMP state machine.
- Drives per-state datapath strobes (PC write, IR write, GPR write, DM write) and path selects.
- Supports ori, lw, sw, lui, addu, subu, sll, beq, bgtz, jal, jr. Data-memory accesses are stalled through a ready handshake.

Parameters:
- RA_IDX, 31, GPR index written by jal (drives wa_sel=2 target in datapath)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- instr  in  32  IR contents from datapath (valid from DECODE onward)
- zero  in  1  ALU result == 0 (rs==rt compare for beq)
- gtz  in  1  GPR[rs] signed > 0 (for bgtz)
- dm_ready  in  1  data memory access complete this cycle
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- npc_sel  out  2  0:PC+4 1:branch target 2:jump target 3:GPR[rs]
- reg_dst  out  2  write-address select 0:rt 1:rd 2:RA_IDX
- alu_src  out  1  0:GPR[rt] 1:extended imm
- mem_to_reg  out  2  0:ALU 1:DM 2:PC+4
- gpr_write  out  1  register file write strobe
- dm_write  out  1  data memory write strobe
- dm_req  out  1  data memory access request
- sign_ext  out  1  1:sign-extend imm16 0:zero-extend
- lui_ext  out  1  imm16<<16
- alu_op  out  3  000 addu, 001 subu, 010 or, 011 sll
- illegal  out  1  one-cycle pulse on unsupported encoding
- state  out  3  current state (debug)
- retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, BR=5, JMP=6.
- Reset (reset=0, asynchronous): state=FETCH, retired=0, all strobes 0.
  - Outputs are combinational from state plus instr. In FETCH they are decode-independent.
  - Reset mid-instruction aborts it with no write and no retire.
- FETCH: ir_write=1, pc_write=1, npc_sel=0. Next state is DECODE.
- DECODE: opcode = instr[31:26]; funct = instr[5:0] when opcode=0.
  - R-type (addu 100001, subu 100011, sll 000000), ori 001101, lui 001111, lw 100011, sw 101011 → EXE.
  - beq 000100, bgtz 000111 → BR.
  - jal 000011, jr (R-type funct 001000) → JMP.
  - Anything else → illegal=1, then FETCH. Treated as a nop; retired does not increment.
- EXE: alu_op/alu_src/sign_ext/lui_ext held per instruction.
  - lw/sw: alu_op=000, alu_src=1, sign_ext=1.
  - ori: alu_op=010, alu_src=1, sign_ext=0.
  - lui: lui_ext=1, alu_src=1, alu_op=010.
  - sll: alu_op=011, shift amount instr[10:6].
  - Next state: lw/sw → MEM; all others → WB.
- MEM: dm_req=1; sw also drives dm_write=1.
  - Stay in MEM while dm_ready=0. dm_write stays high for the whole wait.
  - When dm_ready=1: sw → FETCH and retire; lw → WB.
- WB: gpr_write=1, exactly one cycle.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ori/lui: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Next state FETCH; retire.
- BR: alu_op=001, alu_src=0.
  - pc_write = (beq & zero) | (bgtz & gtz), with npc_sel=1.
  - Untaken branch: no PC write; the PC+4 from FETCH stands.
  - Next state FETCH; retire.
- JMP:
  - jal: pc_write=1, npc_sel=2, gpr_write=1, reg_dst=2, mem_to_reg=2.
  - jr: pc_write=1, npc_sel=3.
  - Next state FETCH; retire.
- Latency in cycles: R/ori/lui 4; sw 4+wait; lw 5+wait; beq/bgtz/jal/jr 3; illegal 2.
- retired increments by 1 on each retire transition and wraps modulo 2^CNT_W.
- Only one of pc_write/gpr_write/dm_write may be asserted in any state, except FETCH (pc+ir) and JMP-jal (pc+gpr).
- dm_ready is ignored outside MEM.

Test Plan:
- Reset: reset=0 for 3 cycles mid-EXE, then release → state=0, retired=0, all strobes 0. First edge after release gives ir_write=1, pc_write=1.
- addu $3,$1,$2 (0x00221821) → states 0,1,2,4,0. Cycle 4 has gpr_write=1, reg_dst=1, alu_op=000. retired=1 after 4 cycles.
- lw (0x8C220004) with dm_ready low for 3 MEM cycles → MEM held 4 cycles with dm_req=1 and dm_write=0. Then WB with mem_to_reg=1, reg_dst=0. 8 cycles total.
- beq (0x10220003): zero=1 → BR has pc_write=1, npc_sel=1. With zero=0 → pc_write=0. Both cases return to FETCH next cycle.
- jal (0x0C000100) → JMP has pc_write=1, npc_sel=2, gpr_write=1, reg_dst=2, mem_to_reg=2. jr $31 (0x03E00008) → npc_sel=3, gpr_write=0.
- Illegal opcode 0xFC000000 → illegal=1 in DECODE only, next state FETCH, retired unchanged.
